// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round controller: spawn, hit/miss scoring, difficulty level.
// Optional build macro MISS_ON_WRONG_EN: a wrong-button press in WAIT counts as a miss.
module mole_round_ctrl #(
  parameter int         NUM_MOLES      = 8,
  parameter int         GAP_TICKS      = 3,
  parameter int         HITS_PER_LEVEL = 5,
  parameter int         MAX_MISSES     = 3,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                 clk_game,
  input  logic                 rst_n,
  input  logic                 game_en,
  input  logic [NUM_MOLES-1:0] btn_pulse,
  input  logic                 timeout_pulse,
  input  logic                 active,
  output logic                 timer_enable,
  output logic                 start,
  output logic [1:0]           level,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic [7:0]           score,
  output logic [1:0]           misses,
  output logic                 game_over
);

  localparam int                 GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0]      GAP_LOAD = GW'(GAP_TICKS - 1);
  localparam int                 HW       = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [HW-1:0]      HIT_MAX  = HW'(HITS_PER_LEVEL);
  localparam logic [3:0]         NM       = 4'(NUM_MOLES);
  localparam logic [1:0]         MISS_MAX = 2'(MAX_MISSES);
  localparam logic [NUM_MOLES-1:0] ONE    = {{(NUM_MOLES-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, GAP, SPAWN, WAIT, OVER} state_t;

  state_t          state;
  logic [7:0]      lfsr;
  logic [GW-1:0]   gap_cnt;
  logic [HW-1:0]   hit_cnt;
  logic [2:0]      prev_idx;
  logic [2:0]      mod_idx;
  logic [2:0]      inc_idx;
  logic [2:0]      spawn_idx;
  logic            hit;
  logic            miss;

  // Fold the 3-bit LFSR slice into range, then step past the previous mole so it never repeats.
  always_comb begin
    mod_idx   = ({1'b0, lfsr[2:0]} >= NM) ? 3'({1'b0, lfsr[2:0]} - NM) : lfsr[2:0];
    inc_idx   = (({1'b0, mod_idx} + 4'd1) == NM) ? 3'd0 : mod_idx + 3'd1;
    spawn_idx = (mod_idx == prev_idx) ? inc_idx : mod_idx;
  end

`ifdef MISS_ON_WRONG_EN
  logic [NUM_MOLES-1:0] cur_mask;
  assign cur_mask = ONE << prev_idx;
  always_comb begin
    hit  = btn_pulse[prev_idx];
    miss = !hit && (timeout_pulse || (|(btn_pulse & ~cur_mask)));
  end
`else
  always_comb begin
    hit  = btn_pulse[prev_idx];
    miss = !hit && timeout_pulse;
  end
`endif

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      gap_cnt      <= '0;
      hit_cnt      <= '0;
      prev_idx     <= '0;
      start        <= 1'b0;
      timer_enable <= 1'b0;
      game_over    <= 1'b0;
      mole_led     <= '0;
      score        <= '0;
      misses       <= '0;
      level        <= '0;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      start <= 1'b0;
      if (!game_en) begin
        state        <= IDLE;
        mole_led     <= '0;
        timer_enable <= 1'b0;
        game_over    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            score        <= '0;
            misses       <= '0;
            hit_cnt      <= '0;
            level        <= '0;
            gap_cnt      <= GAP_LOAD;
            timer_enable <= 1'b1;
            state        <= GAP;
          end
          GAP: begin
            if (gap_cnt == '0) state <= SPAWN;
            else               gap_cnt <= gap_cnt - GW'(1);
          end
          SPAWN: begin
            start    <= 1'b1;
            mole_led <= ONE << spawn_idx;
            prev_idx <= spawn_idx;
            state    <= WAIT;
          end
          WAIT: begin
            if (hit) begin
              if (score != 8'hFF) score <= score + 8'd1;
              if (hit_cnt + HW'(1) == HIT_MAX) begin
                hit_cnt <= '0;
                if (level != 2'd2) level <= level + 2'd1;
              end else begin
                hit_cnt <= hit_cnt + HW'(1);
              end
              mole_led <= '0;
              gap_cnt  <= GAP_LOAD;
              state    <= GAP;
            end else if (miss) begin
              misses <= misses + 2'd1;
              if (misses + 2'd1 == MISS_MAX) begin
                mole_led     <= '1;
                game_over    <= 1'b1;
                timer_enable <= 1'b0;
                state        <= OVER;
              end else begin
                mole_led <= '0;
                gap_cnt  <= GAP_LOAD;
                state    <= GAP;
              end
            end
          end
          OVER:    state <= OVER;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  // The timer only sees start one edge late, so active lags start by a cycle.
  a_idle_on_start: assert property (@(posedge clk_game) disable iff (!rst_n)
    start |-> !active);
  a_active_in_wait: assert property (@(posedge clk_game) disable iff (!rst_n)
    (state == WAIT && !start && !$past(start) && !timeout_pulse) |-> active);
`endif

endmodule
